alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, multi-stage successor of the team's 8-bit pushin/stopin ALU. It adds an operand width parameter, a pipeline depth parameter, an 8-operation opcode set, a high-product output and a zero flag. Every stage is individually stallable, so bubbles collapse under backpressure. It sits between an operand producer and a result consumer, using the same push/stop handshake on both sides.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
DEPTH, 2, number of pipeline register stages; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
pushin  in  1  upstream offers an operation this cycle.
stopout  out  1  upstream must hold pushin and operands; the offer is not accepted.
ctl  in  3  opcode (alu_op_e).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
ci  in  1  carry in.
pushout  out  1  valid result at output.
stopin  in  1  downstream cannot accept the result.
z  out  WIDTH  result, low WIDTH bits.
zh  out  WIDTH  multiply high half; 0 for other ops.
cout  out  1  carry/extension bit.
zf  out  1  z == 0 flag for the result on the output.

Behaviour:
- Reset (async, any time including mid-stream):
  - all stage valids are cleared; pushout=0, stopout=0.
  - z, zh, cout, zf = 0; all in-flight operations are discarded.
- Accept and deliver:
  - input accepted when pushin && !stopout.
  - output consumed when pushout && !stopin.
- Stall chain, with stage index 0 = input side and DEPTH-1 = output:
  - hold[DEPTH-1] = v[DEPTH-1] && stopin.
  - hold[i] = v[i] && hold[i+1].
  - stopout = hold[0], combinational.
  - A held stage keeps its valid and data unchanged.
  - A non-held stage loads from the previous stage, or from the compute logic for stage 0.
  - An invalid stage always loads, so bubbles are squeezed out.
- Latency: a result appears on pushout exactly DEPTH cycles after acceptance when there is no stall. Throughput is 1 per cycle.
- Compute is combinational from a/b/ci/ctl and is captured into stage 0. Later stages only delay.
- Arithmetic, with results truncated to WIDTH except where stated:
  - 0 PASS: z=a, cout=0.
  - 1 ADD: {cout,z} = a + b + ci.
  - 2 SUB: {cout,z} = a + ~b + ci. ci=1 gives a-b, and cout=1 means no borrow.
  - 3 MUL: unsigned 2*WIDTH product P; z=P[WIDTH-1:0], zh=P[2W-1:W], cout=P[WIDTH].
  - 4 AND, 5 OR, 6 XOR: bitwise; cout=0.
  - 7 SHR: z = a >> b[$clog2(WIDTH)-1:0], logical; cout = last bit shifted out (0 if the shift amount is 0).
- zh=0 for every op except MUL.
- zf is computed from the final z and registered with the stage.
- Output data z/zh/cout/zf are stage DEPTH-1 registers. Values are undefined-but-stable while pushout=0; the bench must ignore them then.
- Upstream contract: while stopout=1, the upstream keeps pushin=1 and its operands stable. If pushin drops during stopout, no transfer occurs.
- Simultaneous consume at output and accept at input in the same cycle is legal when the pipe is full and stopin=0. stopout is 0 in that cycle.

Optional Feature:
Macro ALU_PIPE_SAT_EN.
- Defined:
  - ADD saturates z to all-ones when the raw carry is 1.
  - SUB clamps z to 0 when the raw cout is 0 (borrow).
  - cout still reports the raw carry; zf reflects the saturated z.
- Undefined: wrap-around arithmetic as above. No port or parameter difference.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_e (OP_PASS..OP_SHR).
  - WIDTH/DEPTH legal-range constants.
  - Result struct typedef carrying z, zh, cout, zf, parameterised by WIDTH through the module.
- One sub-module, alu_pipe_stage: one valid+data register with load/hold logic and hold output. Generated DEPTH times; the compute logic stays in alu_pipe.

Test Plan:
- WIDTH=8, DEPTH=2: ADD a=0xFF b=0x01 ci=0 -> 2 cycles later pushout=1, z=0x00, cout=1, zf=1, zh=0.
- SUB a=0x05 b=0x07 ci=1 -> z=0xFE, cout=0, zf=0. Then SHR a=0x81 b=0x01 -> z=0x40, cout=1.
- MUL a=0x10 b=0x10 -> z=0x00, zh=0x01, cout=1. MUL 0xFF*0xFF -> z=0x01, zh=0xFE.
- Backpressure: stream 5 ADDs (a=1..5, b=0) while holding stopin=1 for 4 cycles after the first result appears.
  - stopout rises once both stages are full; pushout stays high with z=1 stable.
  - After release, z=1..5 delivered in order, no loss or duplication.
- Reset asserted asynchronously with 2 ops in flight -> pushout and stopout drop immediately, outputs 0, and no stale result after release.
- ALU_PIPE_SAT_EN:
  - ADD 0xF0+0x20 -> z=0xFF, cout=1 (without the macro: z=0x10, cout=1).
  - SUB 0x03-0x09 ci=1 -> z=0x00, zf=1 (without: z=0xFA).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode set and legal parameter ranges for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_SHR  = 3'd7
    } alu_op_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 4;

endpackage

// File: rtl/alu_pipe_stage.sv
// One stallable pipeline slot: valid + data register, holds while itself valid and downstream holds.
module alu_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    input  logic          next_hold,
    output logic          vld,
    output logic [DW-1:0] data,
    output logic          hold
);

    assign hold = vld && next_hold;

    // Data only moves with a valid token, so the output stays stable across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (!hold) begin
            vld <= in_vld;
            if (in_vld) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined push/stop ALU with per-stage stalls; define ALU_PIPE_SAT_EN for saturating ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushin,
    output logic             stopout,
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             pushout,
    input  logic             stopin,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] zh,
    output logic             cout,
    output logic             zf
);

    localparam int SW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] zh;
        logic             cout;
        logic             zf;
    } res_t;

    localparam int RW = $bits(res_t);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_param
        $error("alu_pipe: WIDTH or DEPTH out of legal range");
    end

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] sum, input logic carry);
        return carry ? {WIDTH{1'b1}} : sum;
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] diff, input logic no_borrow);
        return no_borrow ? diff : {WIDTH{1'b0}};
    endfunction

    alu_op_e            op;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH-1:0]   z_c;
    logic [WIDTH-1:0]   zh_c;
    logic               cout_c;
    res_t               res_p0;

    assign op     = alu_op_e'(ctl);
    assign add_w  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign sub_w  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ci};
    assign prod_w = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // A guard bit below a catches the last bit shifted out; it is 0 for a zero shift.
    assign shr_w  = {a, 1'b0} >> b[SW-1:0];

    always_comb begin
        z_c    = '0;
        zh_c   = '0;
        cout_c = 1'b0;
        case (op)
            OP_PASS: z_c = a;
            OP_ADD: begin
`ifdef ALU_PIPE_SAT_EN
                z_c = sat_add(add_w[WIDTH-1:0], add_w[WIDTH]);
`else
                z_c = add_w[WIDTH-1:0];
`endif
                cout_c = add_w[WIDTH];
            end
            OP_SUB: begin
`ifdef ALU_PIPE_SAT_EN
                z_c = sat_sub(sub_w[WIDTH-1:0], sub_w[WIDTH]);
`else
                z_c = sub_w[WIDTH-1:0];
`endif
                cout_c = sub_w[WIDTH];
            end
            OP_MUL: begin
                z_c    = prod_w[WIDTH-1:0];
                zh_c   = prod_w[2*WIDTH-1:WIDTH];
                cout_c = prod_w[WIDTH];
            end
            OP_AND: z_c = a & b;
            OP_OR:  z_c = a | b;
            OP_XOR: z_c = a ^ b;
            OP_SHR: begin
                z_c    = shr_w[WIDTH:1];
                cout_c = shr_w[0];
            end
            default: z_c = a;
        endcase
    end

    // Compute result captured into stage 0
    assign res_p0 = '{z: z_c, zh: zh_c, cout: cout_c, zf: (z_c == '0)};

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] hold;
    res_t             data [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          in_vld;
        logic [RW-1:0] in_data;
        logic          next_hold;

        if (i == 0) begin : g_first
            assign in_vld  = pushin;
            assign in_data = res_p0;
        end else begin : g_next
            assign in_vld  = vld[i-1];
            assign in_data = data[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign next_hold = stopin;
        end else begin : g_inner
            assign next_hold = hold[i+1];
        end

        alu_pipe_stage #(.DW(RW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_vld    (in_vld),
            .in_data   (in_data),
            .next_hold (next_hold),
            .vld       (vld[i]),
            .data      (data[i]),
            .hold      (hold[i])
        );
    end

    // Output stage
    assign stopout = hold[0];
    assign pushout = vld[DEPTH-1];
    assign z       = data[DEPTH-1].z;
    assign zh      = data[DEPTH-1].zh;
    assign cout    = data[DEPTH-1].cout;
    assign zf      = data[DEPTH-1].zf;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized scoreboard bench for alu_pipe (WIDTH=8, DEPTH=2) with directed corner cases.
module tb_alu_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             pushin;
    logic             stopout;
    logic [2:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             pushout;
    logic             stopin;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] zh;
    logic             cout;
    logic             zf;

    alu_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .pushin  (pushin),
        .stopout (stopout),
        .ctl     (ctl),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .pushout (pushout),
        .stopin  (stopin),
        .z       (z),
        .zh      (zh),
        .cout    (cout),
        .zf      (zf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] zh;
        logic             cout;
        logic             zf;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic c);
        logic [63:0] m, r, xa, yb, hi;
        int          n;
        exp_t        e;
        m  = (64'd1 << WIDTH) - 64'd1;
        xa = 64'(x);
        yb = 64'(y);
        r  = 64'd0;
        e  = '0;
        case (op)
            3'd0: r = xa;
            3'd1: begin
                r = xa + yb + 64'(c);
                e.cout = r[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (e.cout) r = m;
`endif
            end
            3'd2: begin
                r = xa + (m - yb) + 64'(c);
                e.cout = r[WIDTH];
`ifdef ALU_PIPE_SAT_EN
                if (!e.cout) r = 64'd0;
`endif
            end
            3'd3: begin
                r = xa * yb;
                hi = r >> WIDTH;
                e.zh = hi[WIDTH-1:0];
                e.cout = r[WIDTH];
            end
            3'd4: r = xa & yb;
            3'd5: r = xa | yb;
            3'd6: r = xa ^ yb;
            default: begin
                n = int'(yb % (64'd1 << $clog2(WIDTH)));
                r = xa >> n;
                e.cout = (n == 0) ? 1'b0 : xa[n-1];
            end
        endcase
        e.z  = r[WIDTH-1:0];
        e.zf = (e.z == '0);
        return e;
    endfunction

    // Scoreboard: signals are stable at the falling edge until the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (pushout && !stopin) begin : consume
                exp_t e;
                if (expq.size() == 0) begin
                    check("spurious_out", 64'(pushout), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("sb_z", 64'(z), 64'(e.z));
                    check("sb_zh", 64'(zh), 64'(e.zh));
                    check("sb_cout", 64'(cout), 64'(e.cout));
                    check("sb_zf", 64'(zf), 64'(e.zf));
                end
            end
            if (pushin && !stopout) begin
                expq.push_back(model(ctl, a, b, ci));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic c);
        bit acc;
        int n;
        n = 0;
        pushin = 1'b1;
        ctl = op;
        a = x;
        b = y;
        ci = c;
        do begin
            @(negedge clk);
            acc = !stopout;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        check("accept_bound", 64'(acc), 64'd1);
        pushin = 1'b0;
    endtask

    task automatic directed(input logic [2:0] op, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic c,
                            input logic [WIDTH-1:0] ez, input logic [WIDTH-1:0] ezh,
                            input logic ecout, input logic ezf);
        int n;
        stopin = 1'b0;
        check("idle_stopout", 64'(stopout), 64'd0);
        pushin = 1'b1;
        ctl = op;
        a = x;
        b = y;
        ci = c;
        @(posedge clk);
        #1;
        pushin = 1'b0;
        n = 1;
        while (!pushout && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(DEPTH));
        check("dir_z", 64'(z), 64'(ez));
        check("dir_zh", 64'(zh), 64'(ezh));
        check("dir_cout", 64'(cout), 64'(ecout));
        check("dir_zf", 64'(zf), 64'(ezf));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        stopin = 1'b0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        bit seen_stop;
        int n;
        logic [WIDTH-1:0] rx, ry;

        rst = 1'b1;
        pushin = 1'b0;
        stopin = 1'b0;
        ctl = 3'd0;
        a = '0;
        b = '0;
        ci = 1'b0;
        #1;
        check("rst_pushout", 64'(pushout), 64'd0);
        check("rst_stopout", 64'(stopout), 64'd0);
        check("rst_z", 64'(z), 64'd0);
        check("rst_zf", 64'(zf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        directed(3'd1, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        directed(3'd2, 8'h05, 8'h07, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0);
        directed(3'd7, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0);
        directed(3'd3, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1);
        directed(3'd3, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0);
`ifdef ALU_PIPE_SAT_EN
        directed(3'd1, 8'hF0, 8'h20, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
        directed(3'd2, 8'h03, 8'h09, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
`else
        directed(3'd1, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0);
        directed(3'd2, 8'h03, 8'h09, 1'b1, 8'hFA, 8'h00, 1'b0, 1'b0);
`endif

        // Backpressure: five ADDs with the output stalled for 4 cycles
        seen_stop = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++) send(3'd1, WIDTH'(k), '0, 1'b0);
            end
            begin
                n = 0;
                while (!pushout && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_first", 64'(pushout), 64'd1);
                stopin = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    #1;
                    check("bp_hold_vld", 64'(pushout), 64'd1);
                    check("bp_hold_z", 64'(z), 64'd1);
                    if (stopout) seen_stop = 1'b1;
                end
                stopin = 1'b0;
            end
        join
        check("bp_stopout_seen", 64'(seen_stop), 64'd1);
        drain();

        // Asynchronous reset with two operations in flight
        stopin = 1'b1;
        pushin = 1'b1;
        ctl = 3'd1;
        a = 8'h11;
        b = 8'h01;
        ci = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h22;
        @(posedge clk);
        #1;
        pushin = 1'b0;
        check("inflight_pushout", 64'(pushout), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pushout", 64'(pushout), 64'd0);
        check("arst_stopout", 64'(stopout), 64'd0);
        check("arst_z", 64'(z), 64'd0);
        check("arst_zh", 64'(zh), 64'd0);
        check("arst_cout", 64'(cout), 64'd0);
        check("arst_zf", 64'(zf), 64'd0);
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stopin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 64'(pushout), 64'd0);
        end

        // Random operations under random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    rx = WIDTH'($urandom);
                    ry = WIDTH'($urandom);
                    send(3'($urandom_range(0, 7)), rx, ry, 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    stopin = ($urandom_range(0, 3) == 0);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
